// File: rtl/fg_prog_sequencer.sv
// Programming initiator for the FG island mux: accepts one cell-program command per handshake and
// sequences decoder setup, settling, Vinj pulse train and release, then strobes done with a status.
module fg_prog_sequencer #(
  parameter int NUM_ISL = 2,
  parameter int ISL_W   = (NUM_ISL > 1) ? $clog2(NUM_ISL) : 1,
  parameter int ROW_W   = 2,
  parameter int COL_W   = 3,
  parameter int SETTLE  = 16,
  parameter int GAP     = 4,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ISL_W-1:0]   cmd_isl,
  input  logic [ROW_W-1:0]   cmd_row,
  input  logic [COL_W-1:0]   cmd_col,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [CNT_W-1:0]   cmd_cnt,
  input  logic               abort,
  output logic [NUM_ISL-1:0] isl_sel,
  output logic [ROW_W-1:0]   vdec_addr,
  output logic [COL_W-1:0]   hdec_addr,
  output logic               dec_en,
  output logic               prog_sw,
  output logic               vinj_pulse,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
);

  // Timer must hold both the widest pulse length and the 8-bit settle/gap values.
  localparam int TMR_W = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] GAP_M1    = TMR_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SETTLE_A = 3'd2,
    S_PULSE    = 3'd3,
    S_GAP      = 3'd4,
    S_RELEASE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [ISL_W-1:0]   isl_q, isl_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               bad_q, bad_d;
  logic               abrt_q, abrt_d;

  logic [NUM_ISL-1:0] isl_sel_q, isl_sel_d;
  logic [ROW_W-1:0]   vdec_q, vdec_d;
  logic [COL_W-1:0]   hdec_q, hdec_d;
  logic               dec_en_q, dec_en_d;
  logic               prog_sw_q, prog_sw_d;
  logic               vinj_q, vinj_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;

  logic               abort_take_s;
  logic [TMR_W-1:0]   len_ld_s;
  state_t             eff_state_s;

  assign abort_take_s = abort && ((state_q == S_SETUP) || (state_q == S_SETTLE_A) ||
                                  (state_q == S_PULSE) || (state_q == S_GAP));
  assign len_ld_s     = (len_q == '0) ? '0 : TMR_W'(len_q - LEN_W'(1));

  // State, command and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      isl_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      tmr_q     <= '0;
      bad_q     <= 1'b0;
      abrt_q    <= 1'b0;
      isl_sel_q <= '0;
      vdec_q    <= '0;
      hdec_q    <= '0;
      dec_en_q  <= 1'b0;
      prog_sw_q <= 1'b0;
      vinj_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      isl_q     <= isl_d;
      row_q     <= row_d;
      col_q     <= col_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      tmr_q     <= tmr_d;
      bad_q     <= bad_d;
      abrt_q    <= abrt_d;
      isl_sel_q <= isl_sel_d;
      vdec_q    <= vdec_d;
      hdec_q    <= hdec_d;
      dec_en_q  <= dec_en_d;
      prog_sw_q <= prog_sw_d;
      vinj_q    <= vinj_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end

  // Next-state, timer and command-latch logic
  always_comb begin
    state_d = state_q;
    isl_d   = isl_q;
    row_d   = row_q;
    col_d   = col_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    tmr_d   = tmr_q;
    bad_d   = bad_q;
    abrt_d  = abrt_q;
    if (abort_take_s) begin
      state_d = S_RELEASE;
      tmr_d   = SETTLE_M1;
      abrt_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            isl_d  = cmd_isl;
            row_d  = cmd_row;
            col_d  = cmd_col;
            len_d  = cmd_len;
            cnt_d  = cmd_cnt;
            abrt_d = 1'b0;
            if ({1'b0, cmd_isl} >= (ISL_W+1)'(NUM_ISL)) begin
              bad_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              bad_d   = 1'b0;
              state_d = S_SETUP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SETUP: begin
          state_d = S_SETTLE_A;
          tmr_d   = SETTLE_M1;
        end
        S_SETTLE_A: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else if (cnt_q == '0) begin
            state_d = S_RELEASE;
            tmr_d   = SETTLE_M1;
          end else begin
            state_d = S_PULSE;
            tmr_d   = len_ld_s;
            left_d  = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          // No gap after the final pulse: go straight to release.
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else if (left_q == '0) begin
            state_d = S_RELEASE;
            tmr_d   = SETTLE_M1;
          end else begin
            state_d = S_GAP;
            tmr_d   = GAP_M1;
          end
        end
        S_GAP: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else begin
            state_d = S_PULSE;
            tmr_d   = len_ld_s;
            left_d  = left_q - CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; an accepted abort already shows release values on the next edge
  always_comb begin
    eff_state_s = abort_take_s ? S_RELEASE : state_q;
    isl_sel_d   = '0;
    vdec_d      = '0;
    hdec_d      = '0;
    dec_en_d    = 1'b0;
    prog_sw_d   = 1'b0;
    vinj_d      = 1'b0;
    done_d      = 1'b0;
    status_d    = 2'b00;
    case (eff_state_s)
      S_SETUP, S_SETTLE_A, S_PULSE, S_GAP: begin
        isl_sel_d = NUM_ISL'(1) << isl_q;
        vdec_d    = row_q;
        hdec_d    = col_q;
        dec_en_d  = 1'b1;
        prog_sw_d = 1'b1;
        vinj_d    = (eff_state_s == S_PULSE);
      end
      S_RELEASE: begin
        vdec_d = row_q;
        hdec_d = col_q;
      end
      S_DONE: begin
        done_d   = 1'b1;
        status_d = bad_q ? 2'b10 : (abrt_q ? 2'b01 : 2'b00);
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign isl_sel    = isl_sel_q;
  assign vdec_addr  = vdec_q;
  assign hdec_addr  = hdec_q;
  assign dec_en     = dec_en_q;
  assign prog_sw    = prog_sw_q;
  assign vinj_pulse = vinj_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: cycle-exact waveform checks per command plus a status
// scoreboard popped on every done strobe.
module tb_fg_prog_sequencer;
  localparam int NUM_ISL = 3;
  localparam int ISL_W   = 2;
  localparam int ROW_W   = 2;
  localparam int COL_W   = 3;
  localparam int SETTLE  = 4;
  localparam int GAP     = 2;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ISL_W-1:0]   cmd_isl = '0;
  logic [ROW_W-1:0]   cmd_row = '0;
  logic [COL_W-1:0]   cmd_col = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [CNT_W-1:0]   cmd_cnt = '0;
  logic               abort = 1'b0;
  logic [NUM_ISL-1:0] isl_sel;
  logic [ROW_W-1:0]   vdec_addr;
  logic [COL_W-1:0]   hdec_addr;
  logic               dec_en, prog_sw, vinj_pulse, busy, done;
  logic [1:0]         status;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_s;

  fg_prog_sequencer #(
    .NUM_ISL(NUM_ISL), .ISL_W(ISL_W), .ROW_W(ROW_W), .COL_W(COL_W),
    .SETTLE(SETTLE), .GAP(GAP), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_isl(cmd_isl), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_len(cmd_len),
    .cmd_cnt(cmd_cnt), .abort(abort), .isl_sel(isl_sel), .vdec_addr(vdec_addr),
    .hdec_addr(hdec_addr), .dec_en(dec_en), .prog_sw(prog_sw), .vinj_pulse(vinj_pulse),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one cycle; it is sampled on the next edge (edge N).
  task automatic send(input int isl, input int row, input int col, input int len, input int cnt,
                      input logic ab, input logic push, input logic [1:0] st);
    chk("ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_isl   = ISL_W'(isl);
    cmd_row   = ROW_W'(row);
    cmd_col   = COL_W'(col);
    cmd_len   = LEN_W'(len);
    cmd_cnt   = CNT_W'(cnt);
    abort     = ab;
    if (push) exp_q.push_back(st);
    step();
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // Check every cycle from N+1 up to the done strobe against the timeline model.
  task automatic run_wave(input int len, input int cnt, input int row, input int col,
                          input logic [NUM_ISL-1:0] sel);
    int l_eff, p0, dec_end, done_k;
    logic ev, ed;
    l_eff   = (len == 0) ? 1 : len;
    p0      = 2 + SETTLE;
    dec_end = (cnt > 0) ? p0 + cnt * l_eff + (cnt - 1) * GAP - 1 : 1 + SETTLE;
    done_k  = dec_end + SETTLE + 1;
    for (int k = 1; k <= done_k; k++) begin
      step();
      ed = (k <= dec_end);
      ev = (cnt > 0) && (k >= p0) && (k <= dec_end) && (((k - p0) % (l_eff + GAP)) < l_eff);
      chk("vinj", vinj_pulse, ev);
      chk("dec_en", dec_en, ed);
      chk("prog_sw", prog_sw, ed);
      chk("isl_sel", isl_sel, ed ? sel : '0);
      chk("vdec", vdec_addr, (k < done_k) ? row : 0);
      chk("hdec", hdec_addr, (k < done_k) ? col : 0);
      chk("done", done, (k == done_k));
      chk("busy", busy, (k < done_k));
    end
  endtask

  // Scoreboard and invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", done, 0);
        end else begin
          exp_s = exp_q.pop_front();
          chk("sb_status", status, exp_s);
        end
      end
      chk("inv_vinj_dec", vinj_pulse & ~dec_en, 0);
      chk("inv_onehot0", $onehot0(isl_sel), 1);
    end
  end

  initial begin
    step();
    step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_vinj", vinj_pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_isl_sel", isl_sel, 0);
    chk("rst_status", status, 0);
    rst = 1'b0;
    step();

    // Nominal two-pulse program, then back-to-back commands on the cycle ready rises
    send(1, 2, 5, 3, 2, 1'b0, 1'b1, 2'b00);
    run_wave(3, 2, 2, 5, 3'b010);
    send(0, 1, 6, 3, 0, 1'b0, 1'b1, 2'b00);
    run_wave(3, 0, 1, 6, 3'b001);
    send(2, 3, 1, 0, 1, 1'b0, 1'b1, 2'b00);
    run_wave(0, 1, 3, 1, 3'b100);
    // Abort together with cmd_valid in IDLE: command accepted, abort ignored
    send(1, 0, 7, 2, 3, 1'b1, 1'b1, 2'b00);
    run_wave(2, 3, 0, 7, 3'b010);

    // Abort during the second pulse
    send(0, 3, 7, 3, 2, 1'b0, 1'b1, 2'b01);
    for (int k = 1; k <= 11; k++) step();
    chk("ab_pre_vinj", vinj_pulse, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_vinj", vinj_pulse, 0);
    chk("ab_dec_en", dec_en, 0);
    chk("ab_prog_sw", prog_sw, 0);
    chk("ab_isl_sel", isl_sel, 0);
    chk("ab_vdec_hold", vdec_addr, 3);
    chk("ab_hdec_hold", hdec_addr, 7);
    for (int k = 13; k <= 16; k++) begin
      step();
      chk("ab_rel_done", done, 0);
      chk("ab_rel_dec", dec_en, 0);
    end
    step();
    chk("ab_done", done, 1);
    chk("ab_vdec_clr", vdec_addr, 0);

    // Out-of-range island
    send(3, 2, 4, 5, 5, 1'b0, 1'b1, 2'b10);
    chk("bad_dec_en_n", dec_en, 0);
    step();
    chk("bad_done", done, 1);
    chk("bad_dec_en", dec_en, 0);
    chk("bad_isl_sel", isl_sel, 0);
    chk("bad_ready", cmd_ready, 1);

    // Abort while idle has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_ab_busy", busy, 0);
    chk("idle_ab_done", done, 0);
    step();
    chk("idle_ab_done2", done, 0);

    // Reset in the middle of a pulse
    send(2, 1, 3, 5, 1, 1'b0, 1'b0, 2'b00);
    for (int k = 1; k <= 7; k++) step();
    chk("rp_vinj_pre", vinj_pulse, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rp_vinj", vinj_pulse, 0);
    chk("rp_dec_en", dec_en, 0);
    chk("rp_prog_sw", prog_sw, 0);
    chk("rp_isl_sel", isl_sel, 0);
    chk("rp_ready", cmd_ready, 1);
    chk("rp_busy", busy, 0);
    chk("rp_done", done, 0);
    for (int k = 0; k < 20; k++) step();

    // Normal operation after the mid-command reset
    send(1, 1, 2, 1, 1, 1'b0, 1'b1, 2'b00);
    run_wave(1, 1, 1, 2, 3'b010);
    step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
